// File: rtl/branch_sequencer.sv
// Multi-cycle branch resolution sequencer: evaluates an RV32I branch, redirects fetch, then holds flush.
// Define BRANCH_STATS_EN to add the saturating stat_taken/stat_total counters.
module branch_sequencer #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W        = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_cntrl,
    input  logic [XLEN-1:0] req_d1,
    input  logic [XLEN-1:0] req_d2,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush,
    output logic            res_valid,
    output logic            res_taken,
    output logic            misalign,
    output logic            busy
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_taken,
    output logic [CNT_W-1:0] stat_total
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, REDIR, FLUSH} state_t;

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

    state_t          state_q, state_d;
    logic [2:0]      cntrl_q, cntrl_d;
    logic [XLEN-1:0] d1_q, d1_d;
    logic [XLEN-1:0] d2_q, d2_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            eq, lt_s, lt_u, taken, misaligned;
    logic [XLEN-1:0] target;

    assign eq     = (d1_q == d2_q);
    assign lt_s   = ($signed(d1_q) < $signed(d2_q));
    assign lt_u   = (d1_q < d2_q);
    // Target wraps modulo 2^XLEN; the carry out is intentionally dropped.
    assign target = pc_q + imm_q;

    always_comb begin
        taken = 1'b0;
        case (cntrl_q)
            3'b001:  taken = eq;
            3'b010:  taken = !eq;
            3'b011:  taken = lt_s;
            3'b100:  taken = !lt_s;
            3'b101:  taken = lt_u;
            3'b110:  taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign misaligned = taken && (target[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        cntrl_d    = cntrl_q;
        d1_d       = d1_q;
        d2_d       = d2_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        redir_pc_d = redir_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cntrl_d = req_cntrl;
                    d1_d    = req_d1;
                    d2_d    = req_d2;
                    pc_d    = req_pc;
                    imm_d   = req_imm;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (taken && !misaligned) begin
                    redir_pc_d = target;
                    state_d    = REDIR;
                end else begin
                    state_d = IDLE;
                end
            end
            REDIR: begin
                if (redir_ready) begin
                    if (FLUSH_CYCLES > 0) begin
                        cnt_d   = CNT_LOAD;
                        state_d = FLUSH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cntrl_q    <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            pc_q       <= '0;
            imm_q      <= '0;
            redir_pc_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cntrl_q    <= cntrl_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            redir_pc_q <= redir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs decode straight from flops, so an async reset clears them at once.
    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == EVAL);
    assign res_taken   = res_valid && taken;
    assign misalign    = res_valid && misaligned;
    assign redir_valid = (state_q == REDIR);
    assign redir_pc    = redir_pc_q;
    assign flush       = (state_q == FLUSH);

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] stat_taken_q, stat_taken_d;
    logic [CNT_W-1:0] stat_total_q, stat_total_d;

    always_comb begin
        stat_taken_d = stat_taken_q;
        stat_total_d = stat_total_q;
        if (res_valid) begin
            if (stat_total_q != '1) stat_total_d = stat_total_q + 1'b1;
            if (res_taken && (stat_taken_q != '1)) stat_taken_d = stat_taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_taken_q <= '0;
            stat_total_q <= '0;
        end else begin
            stat_taken_q <= stat_taken_d;
            stat_total_q <= stat_total_d;
        end
    end

    assign stat_taken = stat_taken_q;
    assign stat_total = stat_total_q;
`endif

endmodule
